// File: rtl/rs485_frame_rx.sv
// RS-485 frame receiver: AA, ADDR, CMD, LEN, payload, CHK.
// Byte-driven FSM with inter-byte timeout and one-cycle result pulses.
module rs485_frame_rx #(
  parameter logic [7:0]  DEV_ADDR    = 8'h01,
  parameter int unsigned TIMEOUT_CYC = 21700
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        frame_valid,
  output logic [7:0]  frame_cmd,
  output logic [3:0]  frame_len,
  output logic [63:0] frame_payload,
  output logic        err_chk,
  output logic        err_len,
  output logic        err_timeout,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    addr_q;
  logic [7:0]    cmd_q;
  logic [7:0]    sum_q;
  logic [3:0]    len_q;
  logic [2:0]    idx_q;
  logic [63:0]   pay_q;
  logic          expire;
  logic          addr_ok;

  // A strobe on the expiry cycle keeps the frame alive.
  assign expire  = (state != S_IDLE) && !rx_done &&
                   (cnt == CW'(TIMEOUT_CYC - 1));
  assign addr_ok = (addr_q == DEV_ADDR) || (addr_q == 8'hFF);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      cmd_q         <= '0;
      sum_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      pay_q         <= '0;
      frame_valid   <= 1'b0;
      frame_cmd     <= '0;
      frame_len     <= '0;
      frame_payload <= '0;
      err_chk       <= 1'b0;
      err_len       <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;

      if (rx_done || state == S_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      if (expire) begin
        state       <= S_IDLE;
        err_timeout <= 1'b1;
      end else if (rx_done) begin
        unique case (state)
          S_IDLE: begin
            if (rx_data == 8'hAA) begin
              state <= S_ADDR;
              pay_q <= '0;
              idx_q <= '0;
            end
          end
          S_ADDR: begin
            addr_q <= rx_data;
            sum_q  <= rx_data;
            state  <= S_CMD;
          end
          S_CMD: begin
            cmd_q <= rx_data;
            sum_q <= sum_q + rx_data;
            state <= S_LEN;
          end
          S_LEN: begin
            sum_q <= sum_q + rx_data;
            len_q <= rx_data[3:0];
            if (rx_data > 8'd8) begin
              state   <= S_IDLE;
              err_len <= 1'b1;
            end else if (rx_data == 8'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            pay_q[{idx_q, 3'b000} +: 8] <= rx_data;
            sum_q <= sum_q + rx_data;
            idx_q <= idx_q + 3'd1;
            if ({1'b0, idx_q} == len_q - 4'd1)
              state <= S_CHK;
          end
          S_CHK: begin
            state <= S_IDLE;
            if (rx_data != sum_q) begin
              err_chk <= 1'b1;
            end else if (addr_ok) begin
              frame_valid   <= 1'b1;
              frame_cmd     <= cmd_q;
              frame_len     <= len_q;
              frame_payload <= pay_q;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs485_frame_rx.sv
// Scoreboard bench for rs485_frame_rx: directed frames in,
// expected pulses queued and checked by an independent monitor.
module tb_rs485_frame_rx;

  localparam int TO = 21700;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [1:0]  kind;
    int          cyc;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] pay;
  } exp_t;

  localparam logic [1:0] K_OK = 2'd0;
  localparam logic [1:0] K_CHK = 2'd1;
  localparam logic [1:0] K_LEN = 2'd2;
  localparam logic [1:0] K_TO = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [3:0]  frame_len;
  logic [63:0] frame_payload;
  logic        err_chk;
  logic        err_len;
  logic        err_timeout;
  logic        busy;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_edge = 0;
  exp_t sb[$];
  bq_t  seq;

  rs485_frame_rx #(.DEV_ADDR(8'h01), .TIMEOUT_CYC(TO)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .frame_valid  (frame_valid),
    .frame_cmd    (frame_cmd),
    .frame_len    (frame_len),
    .frame_payload(frame_payload),
    .err_chk      (err_chk),
    .err_len      (err_len),
    .err_timeout  (err_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    last_edge = cyc;
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input int c,
                      input logic [7:0] cm, input logic [3:0] ln,
                      input logic [63:0] p);
    exp_t e;
    e.kind = k;
    e.cyc = c;
    e.cmd = cm;
    e.len = ln;
    e.pay = p;
    sb.push_back(e);
  endtask

  task automatic chk_held(input string tag, input logic [7:0] cm,
                          input logic [3:0] ln, input logic [63:0] p);
    chk({tag, "_cmd"}, 64'(frame_cmd), 64'(cm));
    chk({tag, "_len"}, 64'(frame_len), 64'(ln));
    chk({tag, "_pay"}, frame_payload, p);
  endtask

  // Monitor: pops one expectation per observed pulse.
  always @(negedge clk) begin
    int n;
    logic [1:0] k;
    exp_t e;
    if (rst_n === 1'b1) begin
      n = int'(frame_valid) + int'(err_chk) + int'(err_len) +
          int'(err_timeout);
      if (n > 1) chk("onehot", 64'(n), 64'd1);
      if (n != 0) begin
        k = frame_valid ? K_OK : err_chk ? K_CHK :
            err_len ? K_LEN : K_TO;
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 64'(k), 64'hFF);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", 64'(k), 64'(e.kind));
          chk("pulse_cyc", 64'(cyc), 64'(e.cyc));
          if (e.kind == K_OK) begin
            chk("mon_cmd", 64'(frame_cmd), 64'(e.cmd));
            chk("mon_len", 64'(frame_len), 64'(e.len));
            chk("mon_pay", frame_payload, e.pay);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    idle(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({frame_valid, err_chk, err_len, err_timeout}),
        64'd0);
    chk_held("rst", 8'h00, 4'd0, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Checksum 01+10+02+55+66 = CE.
    seq = {8'hAA, 8'h01, 8'h10, 8'h02, 8'h55, 8'h66, 8'hCE};
    send_seq(seq);
    push(K_OK, last_edge, 8'h10, 4'd2, 64'h6655);
    idle(3);

    seq = {8'hAA, 8'h01, 8'h10, 8'h02, 8'h55, 8'h66, 8'hCD};
    send_seq(seq);
    push(K_CHK, last_edge, 8'h00, 4'd0, 64'd0);
    idle(3);
    chk_held("after_chk", 8'h10, 4'd2, 64'h6655);

    seq = {8'hAA, 8'h01, 8'h10, 8'h09};
    send_seq(seq);
    push(K_LEN, last_edge, 8'h00, 4'd0, 64'd0);
    chk("len_busy", 64'(busy), 64'd0);
    idle(3);

    seq = {8'hAA, 8'h07, 8'h20, 8'h00, 8'h27};
    send_seq(seq);
    idle(3);
    chk_held("foreign", 8'h10, 4'd2, 64'h6655);

    seq = {8'hAA, 8'h07, 8'h20, 8'h00, 8'h28};
    send_seq(seq);
    push(K_CHK, last_edge, 8'h00, 4'd0, 64'd0);
    idle(3);

    seq = {8'hAA, 8'hFF, 8'h20, 8'h00, 8'h1F};
    send_seq(seq);
    push(K_OK, last_edge, 8'h20, 4'd0, 64'd0);
    idle(3);

    seq = {8'h12, 8'h34, 8'h00};
    send_seq(seq);
    chk("garbage_busy", 64'(busy), 64'd0);
    idle(3);

    seq = {8'hAA, 8'h01};
    send_seq(seq);
    push(K_TO, last_edge + TO, 8'h00, 4'd0, 64'd0);
    idle(TO);
    chk("to_busy", 64'(busy), 64'd0);
    idle(3);

    // Strobe on the expiry cycle keeps the frame going.
    seq = {8'hAA, 8'h01};
    send_seq(seq);
    idle(TO - 1);
    seq = {8'h10, 8'h00, 8'h11};
    send_seq(seq);
    push(K_OK, last_edge, 8'h10, 4'd0, 64'd0);
    idle(3);

    seq = {8'hAA, 8'h01, 8'h05, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
           8'h05, 8'h06, 8'h07, 8'h08, 8'h32};
    send_seq(seq);
    push(K_OK, last_edge, 8'h05, 4'd8, 64'h0807060504030201);
    idle(3);

    seq = {8'hAA, 8'h01, 8'h10};
    send_seq(seq);
    rst_n = 1'b0;
    idle(2);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk_held("mid_rst", 8'h00, 4'd0, 64'd0);
    rst_n = 1'b1;
    seq = {8'hAA, 8'h01, 8'h33, 8'h01, 8'hAA, 8'hDF};
    send_seq(seq);
    push(K_OK, last_edge, 8'h33, 4'd1, 64'hAA);
    idle(3);

    seq = {8'hAA, 8'h01, 8'h10, 8'h03, 8'hAA, 8'h01, 8'hAA, 8'h69};
    send_seq(seq);
    push(K_OK, last_edge, 8'h10, 4'd3, 64'hAA01AA);
    seq = {8'hAA, 8'hFF, 8'h42, 8'h02, 8'hAA, 8'hAA, 8'h97};
    send_seq(seq);
    push(K_OK, last_edge, 8'h42, 4'd2, 64'hAAAA);
    idle(5);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
